modulo_contador_entrada_saida: RTL and testbench

- Upstream stage of the occupancy path. Filters two raw presence sensors (entry and exit), turns each confirmed rising edge into a one-cycle event, and keeps a saturating 7-bit up/down occupancy count.
- reg_data drives the >99 comparator stage directly.
- That comparator's flag returns here as cont_superior_99 and blocks further entries while it is high.

---
 rtl/modulo_contador_entrada_saida_pkg.sv | 8 +
 rtl/modulo_contador_entrada_saida_filtro_sensor.sv | 37 +++
 rtl/modulo_contador_entrada_saida.sv | 49 ++++
 tb/tb_modulo_contador_entrada_saida.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/modulo_contador_entrada_saida_pkg.sv
// modulo_contador_entrada_saida_pkg: shared widths, defaults and count operations for the occupancy counter
package modulo_contador_entrada_saida_pkg;
  localparam int COUNT_W = 7;
  localparam int DEB_W = 4;
  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int MAX_COUNT_DEF = 127;
  typedef enum logic [1:0] {OP_HOLD, OP_INC, OP_DEC, OP_CLR} op_t;
endpackage

// File: rtl/modulo_contador_entrada_saida_filtro_sensor.sv
// filtro_sensor: two-flop synchroniser, debounce filter and registered rising-edge pulse for one sensor
module filtro_sensor
  import modulo_contador_entrada_saida_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sensor_in,
  output logic pulso_out
);
  logic [1:0] sync_q, vld_q;
  logic [DEB_W-1:0] cnt_q, cnt_d;
  logic filt_q, arm_q, flip;
  always_comb begin
    flip = (sync_q[1] != filt_q) && (cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1));
    cnt_d = (sync_q[1] == filt_q || flip) ? '0 : cnt_q + 1'b1;
  end
  // arm_q waits for a real low sample so a sensor already high at reset release never fires
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      vld_q <= '0;
      cnt_q <= '0;
      filt_q <= 1'b0;
      arm_q <= 1'b0;
      pulso_out <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], sensor_in};
      vld_q <= {vld_q[0], 1'b1};
      cnt_q <= cnt_d;
      filt_q <= filt_q ^ flip;
      arm_q <= arm_q | (vld_q[1] & ~sync_q[1]);
      pulso_out <= flip & sync_q[1] & arm_q;
    end
  end
endmodule

// File: rtl/modulo_contador_entrada_saida.sv
// modulo_contador_entrada_saida: filtered entry/exit events driving a saturating up/down occupancy count
module modulo_contador_entrada_saida
  import modulo_contador_entrada_saida_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int MAX_COUNT = MAX_COUNT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sensor_entrada,
  input  logic               sensor_saida,
  input  logic               zerar,
  input  logic               cont_superior_99,
  output logic [COUNT_W-1:0] reg_data,
  output logic               evento_entrada,
  output logic               evento_saida,
  output logic               entrada_bloqueada
);
  logic [COUNT_W-1:0] reg_q, reg_d;
  logic bloq_d;
  op_t op;
  filtro_sensor #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_entrada (
    .clk(clk), .rst_n(rst_n), .sensor_in(sensor_entrada), .pulso_out(evento_entrada)
  );
  filtro_sensor #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_saida (
    .clk(clk), .rst_n(rst_n), .sensor_in(sensor_saida), .pulso_out(evento_saida)
  );
  always_comb begin
    bloq_d = !zerar && evento_entrada && !evento_saida
             && (cont_superior_99 || reg_q == COUNT_W'(MAX_COUNT));
    op = zerar ? OP_CLR :
         (evento_entrada == evento_saida) ? OP_HOLD :
         evento_entrada ? (bloq_d ? OP_HOLD : OP_INC) :
         (reg_q == '0) ? OP_HOLD : OP_DEC;
    reg_d = (op == OP_CLR) ? '0 :
            (op == OP_INC) ? reg_q + 1'b1 :
            (op == OP_DEC) ? reg_q - 1'b1 : reg_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_q <= '0;
      entrada_bloqueada <= 1'b0;
    end else begin
      reg_q <= reg_d;
      entrada_bloqueada <= bloq_d;
    end
  end
  assign reg_data = reg_q;
endmodule

// File: tb/tb_modulo_contador_entrada_saida.sv
// tb_modulo_contador_entrada_saida: directed table, exact-latency sequence and randomized run against a queue-based model
module tb_modulo_contador_entrada_saida;
  localparam int DEB = 4;
  localparam int MAXC = 127;
  logic clk = 1'b0;
  logic rst_n, sensor_entrada, sensor_saida, zerar, cont_superior_99;
  logic [6:0] reg_data;
  logic evento_entrada, evento_saida, entrada_bloqueada;
  int tests = 0, fails = 0;
  int cnt_ne, cnt_ns, cnt_nb;
  bit chk_on = 1'b0;
  always #5 clk = ~clk;

  modulo_contador_entrada_saida #(.DEBOUNCE_CYCLES(DEB), .MAX_COUNT(MAXC)) dut (
    .clk(clk), .rst_n(rst_n), .sensor_entrada(sensor_entrada), .sensor_saida(sensor_saida),
    .zerar(zerar), .cont_superior_99(cont_superior_99), .reg_data(reg_data),
    .evento_entrada(evento_entrada), .evento_saida(evento_saida), .entrada_bloqueada(entrada_bloqueada)
  );

  typedef struct {
    int pre;
    logic e, s, z, cs, r;
    int n, rd, ne, ns, nb;
  } vec_t;
  vec_t tbl [29];

  bit rawh [2][$];
  bit synh [2][$];
  int nseen [2];
  bit filt [2], armed [2], m_ev [2];
  int m_cnt;
  bit m_blk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // A sensor's filtered level flips once its last DEB synchronised samples all disagree with it
  task automatic sens(input int k, input bit raw, output bit ev);
    bit sy, diff;
    nseen[k]++;
    rawh[k].push_back(raw);
    if (rawh[k].size() > 3) void'(rawh[k].pop_front());
    sy = (nseen[k] >= 3) ? rawh[k][0] : 1'b0;
    synh[k].push_back(sy);
    if (synh[k].size() > DEB) void'(synh[k].pop_front());
    diff = (synh[k].size() == DEB);
    for (int i = 0; i < synh[k].size(); i++) if (synh[k][i] == filt[k]) diff = 1'b0;
    ev = 1'b0;
    if (diff) begin
      filt[k] = !filt[k];
      ev = filt[k] && armed[k];
    end
    if (nseen[k] >= 3 && !sy) armed[k] = 1'b1;
  endtask

  always @(posedge clk) begin
    bit ev0, ev1;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        rawh[k].delete();
        synh[k].delete();
        nseen[k] = 0;
        filt[k] = 1'b0;
        armed[k] = 1'b0;
        m_ev[k] = 1'b0;
      end
      m_cnt = 0;
      m_blk = 1'b0;
    end else begin
      m_blk = 1'b0;
      if (zerar) m_cnt = 0;
      else if (m_ev[0] && !m_ev[1]) begin
        if (cont_superior_99 || m_cnt == MAXC) m_blk = 1'b1;
        else m_cnt++;
      end else if (m_ev[1] && !m_ev[0] && m_cnt > 0) m_cnt--;
      sens(0, sensor_entrada, ev0);
      sens(1, sensor_saida, ev1);
      m_ev[0] = ev0;
      m_ev[1] = ev1;
    end
  end

  always @(negedge clk) if (chk_on) begin
    chk("model_reg_data", reg_data, m_cnt);
    chk("model_evento_entrada", evento_entrada, m_ev[0]);
    chk("model_evento_saida", evento_saida, m_ev[1]);
    chk("model_entrada_bloqueada", entrada_bloqueada, m_blk);
  end

  task automatic step(input logic e, input logic s, input logic z, input logic cs, input logic r, input int n);
    cnt_ne = 0;
    cnt_ns = 0;
    cnt_nb = 0;
    repeat (n) begin
      @(negedge clk);
      sensor_entrada = e;
      sensor_saida = s;
      zerar = z;
      cont_superior_99 = cs;
      rst_n = !r;
      @(posedge clk);
      #1;
      cnt_ne += int'(evento_entrada === 1'b1);
      cnt_ns += int'(evento_saida === 1'b1);
      cnt_nb += int'(entrada_bloqueada === 1'b1);
    end
  endtask

  task automatic entries(input int n);
    repeat (n) begin
      step(1, 0, 0, 0, 0, 7);
      step(0, 0, 0, 0, 0, 7);
    end
  endtask

  initial begin
    tbl = '{
      '{0,  0,0,0,0,0,  8,   1,0,0,0},
      '{4,  0,1,0,0,0,  3,   5,0,0,0},
      '{0,  0,0,0,0,0,  8,   5,0,0,0},
      '{0,  0,1,0,0,0,  7,   4,0,1,0},
      '{0,  0,0,0,0,0,  7,   4,0,0,0},
      '{0,  0,0,1,0,0,  1,   0,0,0,0},
      '{0,  0,1,0,0,0,  7,   0,0,1,0},
      '{0,  0,0,0,0,0,  7,   0,0,0,0},
      '{10, 1,1,0,0,0,  7,  10,1,1,0},
      '{0,  0,0,0,0,0,  7,  10,0,0,0},
      '{0,  1,0,0,0,0,  6,  10,1,0,0},
      '{0,  1,0,1,1,0,  1,   0,0,0,0},
      '{0,  0,0,0,0,0,  7,   0,0,0,0},
      '{99, 1,0,0,0,0,  7, 100,1,0,0},
      '{0,  0,0,0,0,0,  7, 100,0,0,0},
      '{0,  1,0,0,1,0,  7, 100,1,0,1},
      '{0,  0,0,0,1,0,  7, 100,0,0,0},
      '{0,  0,1,0,1,0,  7,  99,0,1,0},
      '{0,  0,0,0,0,0,  7,  99,0,0,0},
      '{28, 1,0,0,0,0,  7, 127,1,0,1},
      '{0,  0,0,0,0,0,  7, 127,0,0,0},
      '{0,  0,1,0,0,0,  7, 126,0,1,0},
      '{0,  0,0,0,0,0,  7, 126,0,0,0},
      '{0,  1,0,0,0,0,  4, 126,0,0,0},
      '{0,  1,0,0,0,1,  1,   0,0,0,0},
      '{0,  1,0,0,0,0, 12,   0,0,0,0},
      '{0,  0,0,0,0,0,  8,   0,0,0,0},
      '{0,  1,0,0,0,0,  7,   1,1,0,0},
      '{0,  0,0,0,0,0,  7,   1,0,0,0}
    };
    rst_n = 1'b0;
    sensor_entrada = 1'b0;
    sensor_saida = 1'b0;
    zerar = 1'b0;
    cont_superior_99 = 1'b0;
    step(0, 0, 0, 0, 1, 3);
    chk_on = 1'b1;
    chk("rst_reg_data", reg_data, 0);
    chk("rst_evento_entrada", evento_entrada, 0);
    chk("rst_evento_saida", evento_saida, 0);
    chk("rst_entrada_bloqueada", entrada_bloqueada, 0);
    step(0, 0, 0, 0, 0, 3);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      sensor_entrada = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("lat_evento_c%0d", i), evento_entrada, (i == 6) ? 1 : 0);
      chk($sformatf("lat_reg_c%0d", i), reg_data, (i >= 7) ? 1 : 0);
    end
    for (int v = 0; v < 29; v++) begin
      entries(tbl[v].pre);
      step(tbl[v].e, tbl[v].s, tbl[v].z, tbl[v].cs, tbl[v].r, tbl[v].n);
      chk($sformatf("vec%0d_reg", v), reg_data, tbl[v].rd);
      chk($sformatf("vec%0d_n_entrada", v), cnt_ne, tbl[v].ne);
      chk($sformatf("vec%0d_n_saida", v), cnt_ns, tbl[v].ns);
      chk($sformatf("vec%0d_n_bloq", v), cnt_nb, tbl[v].nb);
    end
    for (int i = 0; i < 400; i++) begin
      logic z, r;
      z = ($urandom_range(0, 19) == 0);
      r = ($urandom_range(0, 99) == 0);
      step($urandom_range(0, 1), $urandom_range(0, 1), z, $urandom_range(0, 3) == 0, r,
           (z || r) ? 1 : $urandom_range(1, 10));
    end
    step(0, 0, 0, 0, 0, 2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
